// File: rtl/hospital_rover.sv
`default_nettype none
// ============================================================================
// Module   : hospital_rover
// Purpose  : Location sequencer for an autonomous hospital delivery rover.
//            The rover tours a fixed ring of stops (HOME, WARD_A, WARD_B,
//            PHARMACY, ICU for the default build). It advances one stop per
//            clock while move_switch_i is high and dwells while it is low.
// Ports    : clk_i          - system clock, rising-edge active
//            reset_i        - synchronous active-high reset (wins over moves)
//            move_switch_i  - 1 = advance one stop this cycle, 0 = hold
//            current_loc_o  - registered 3-bit code of the current stop
// Params   : NUM_LOCS (2..8) - number of stops, codes 0..NUM_LOCS-1
//            HOME_LOC        - stop code loaded on reset, < NUM_LOCS
// Revision : 1.0 - initial release
// ============================================================================
module hospital_rover #(
  parameter int NUM_LOCS = 5,
  parameter int HOME_LOC = 0
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       move_switch_i,
  output logic [2:0] current_loc_o
);

  // State codes double as stop codes; these names cover the default ring.
  localparam logic [2:0] LOC_HOME     = 3'd0;
  localparam logic [2:0] LOC_WARD_A   = 3'd1;
  localparam logic [2:0] LOC_WARD_B   = 3'd2;
  localparam logic [2:0] LOC_PHARMACY = 3'd3;
  localparam logic [2:0] LOC_ICU      = 3'd4;

  // The count is held one bit wider than the state so that NUM_LOCS = 8
  // remains representable in the illegal-state compare.
  localparam logic [3:0] NUM_LOCS_W = 4'(NUM_LOCS);
  localparam logic [2:0] LAST_LOC   = 3'(NUM_LOCS - 1);
  localparam logic [2:0] RESET_LOC  = 3'(HOME_LOC);

  logic [2:0] state_q;
  logic [2:0] state_d;
  logic       illegal;
  logic       at_last;

  assign illegal = ({1'b0, state_q} >= NUM_LOCS_W);
  assign at_last = (state_q == LAST_LOC);

  // State register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= RESET_LOC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A non-1 move_switch_i (including X in simulation)
  // falls through to the dwell case.
  always_comb begin
    state_d = state_q;
    if (illegal) begin
      state_d = RESET_LOC;
    end else if (move_switch_i) begin
      state_d = at_last ? LOC_HOME : (state_q + 3'd1);
    end
  end

  // Output logic: the display sees the state register directly, so there is
  // no combinational path from move_switch_i. Because the state never holds
  // a code >= NUM_LOCS, the bits above clog2(NUM_LOCS) are always 0.
  always_comb begin
    current_loc_o = state_q;
  end

  // Named codes are kept for readability of waveforms and future dispatch
  // decoding; tie them off so they do not read as dangling.
  logic unused_names;
  assign unused_names = ^{LOC_WARD_A, LOC_WARD_B, LOC_PHARMACY, LOC_ICU};

endmodule
`default_nettype wire

// File: tb/tb_hospital_rover.sv
`default_nettype none
// ============================================================================
// Module   : tb_hospital_rover
// Purpose  : Self-checking bench for hospital_rover. Drives a default
//            5-stop build and a 3-stop build side by side; the expected stop
//            for each edge is queued by the stimulus and compared by a
//            separate monitor after the edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hospital_rover;

  typedef struct {
    logic [2:0] value;
    string      name;
  } exp_t;

  logic       clk;
  logic       reset5;
  logic       move5;
  logic [2:0] loc5;
  logic       reset3;
  logic       move3;
  logic [2:0] loc3;

  exp_t q5[$];
  exp_t q3[$];

  int tests_run;
  int tests_failed;

  hospital_rover #(.NUM_LOCS(5), .HOME_LOC(0)) u_dut5 (
    .clk_i         (clk),
    .reset_i       (reset5),
    .move_switch_i (move5),
    .current_loc_o (loc5)
  );

  hospital_rover #(.NUM_LOCS(3), .HOME_LOC(0)) u_dut3 (
    .clk_i         (clk),
    .reset_i       (reset3),
    .move_switch_i (move3),
    .current_loc_o (loc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: the output is a plain register, so every edge presents a new
  // value; compare it 1 time unit after the edge against the queued entry.
  always @(posedge clk) begin
    #1;
    if (q5.size() > 0) begin
      exp_t e;
      e = q5.pop_front();
      tests_run++;
      if (loc5 !== e.value) begin
        tests_failed++;
        $display("FAIL %s (N=5): got %0d, expected %0d", e.name, loc5, e.value);
      end
    end
    if (q3.size() > 0) begin
      exp_t e;
      e = q3.pop_front();
      tests_run++;
      if (loc3 !== e.value) begin
        tests_failed++;
        $display("FAIL %s (N=3): got %0d, expected %0d", e.name, loc3, e.value);
      end
    end
  end

  // One clock edge of stimulus for both builds, queuing the hand-computed
  // expected stop that each should show after the edge.
  task automatic step(input logic r5, input logic m5, input logic [2:0] e5,
                      input logic r3, input logic m3, input logic [2:0] e3,
                      input string name);
    exp_t a;
    exp_t b;
    @(negedge clk);
    reset5 = r5;
    move5  = m5;
    reset3 = r3;
    move3  = m3;
    a.value = e5; a.name = name; q5.push_back(a);
    b.value = e3; b.name = name; q3.push_back(b);
    @(posedge clk);
  endtask

  // Stimulus on the 5-stop build while the 3-stop build is held in reset.
  task automatic s5(input logic r, input logic m, input logic [2:0] e, input string name);
    step(r, m, e, 1'b1, 1'b0, 3'd0, name);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset5 = 1'b0; move5 = 1'bx;
    reset3 = 1'b0; move3 = 1'bx;

    // 1. Reset with move_switch X, then dwell on 0 / X.
    s5(1'b1, 1'bx, 3'd0, "reset_x");
    s5(1'b0, 1'b0, 3'd0, "dwell0_low");
    s5(1'b0, 1'bx, 3'd0, "dwell0_x");

    // 2. Four moves from HOME, then hold at ICU.
    s5(1'b0, 1'b1, 3'd1, "move_1");
    s5(1'b0, 1'b1, 3'd2, "move_2");
    s5(1'b0, 1'b1, 3'd3, "move_3");
    s5(1'b0, 1'b1, 3'd4, "move_4");
    s5(1'b0, 1'b0, 3'd4, "hold_4");

    // 3. Wrap ICU -> HOME and continue, then hold at PHARMACY.
    s5(1'b0, 1'b1, 3'd0, "wrap_0");
    s5(1'b0, 1'b1, 3'd1, "wrap_1");
    s5(1'b0, 1'b1, 3'd2, "wrap_2");
    s5(1'b0, 1'b1, 3'd3, "wrap_3");
    s5(1'b0, 1'b0, 3'd3, "hold_3");

    // 4. From reset, three bursts of (1,1,1,1,0): 1,2,3,4,4 / 0,1,2,3,3 / 4,0,1,2,2.
    s5(1'b1, 1'b0, 3'd0, "burst_reset");
    s5(1'b0, 1'b1, 3'd1, "b1_1");
    s5(1'b0, 1'b1, 3'd2, "b1_2");
    s5(1'b0, 1'b1, 3'd3, "b1_3");
    s5(1'b0, 1'b1, 3'd4, "b1_4");
    s5(1'b0, 1'b0, 3'd4, "b1_hold");
    s5(1'b0, 1'b1, 3'd0, "b2_1");
    s5(1'b0, 1'b1, 3'd1, "b2_2");
    s5(1'b0, 1'b1, 3'd2, "b2_3");
    s5(1'b0, 1'b1, 3'd3, "b2_4");
    s5(1'b0, 1'b0, 3'd3, "b2_hold");
    s5(1'b0, 1'b1, 3'd4, "b3_1");
    s5(1'b0, 1'b1, 3'd0, "b3_2");
    s5(1'b0, 1'b1, 3'd1, "b3_3");
    s5(1'b0, 1'b1, 3'd2, "b3_4");
    s5(1'b0, 1'b0, 3'd2, "b3_final");

    // 5. Move to PHARMACY, then reset with move high: reset wins.
    s5(1'b0, 1'b1, 3'd3, "pre_reset_3");
    s5(1'b1, 1'b1, 3'd0, "reset_wins");
    s5(1'b0, 1'b1, 3'd1, "post_reset_move");

    // 6. Three-stop build: seven moves give 1,2,0,1,2,0,1 while the
    //    5-stop build dwells at 1.
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd1, "n3_m1");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd2, "n3_m2");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd0, "n3_m3");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd1, "n3_m4");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd2, "n3_m5");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd0, "n3_m6");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b1, 3'd1, "n3_m7");
    step(1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 3'd1, "n3_hold");

    // Let the monitor drain; any entry left behind is a lost comparison.
    repeat (3) @(negedge clk);
    tests_run++;
    if (q5.size() != 0 || q3.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: got %0d/%0d pending, expected 0/0", q5.size(), q3.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
